uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received character, together with that character's parity and frame error status, into a first-word-fall-through FIFO. Host logic then drains the FIFO through a valid/ready pop interface. The block absorbs bursts of back-to-back frames and flags FIFO overflow separately from the receiver's own overrun flag.

## Interface
Parameters:
- DATA_WIDTH, 8, character width in bits; must match the receiver (5–8).
- DEPTH, 16, number of entries; power of two, ≥ 2.
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  DATA_WIDTH  received character from the receiver.
- rx_valid  in  1  single-cycle strobe; write request.
- parity_error  in  1  parity status of the character on rx_data, sampled with rx_valid.
- frame_error  in  1  frame status of the character on rx_data, sampled with rx_valid.
- flush  in  1  synchronous clear of FIFO contents.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  DATA_WIDTH  head character.
- rd_parity_err  out  1  parity error bit stored with the head entry.
- rd_frame_err  out  1  frame error bit stored with the head entry.
- rd_valid  out  1  head entry is valid; equals !empty.
- count  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- fifo_overrun  out  1  sticky flag: a write was dropped.
- clear_overrun  in  1  clears fifo_overrun.

## Operation
- Storage: DEPTH × (DATA_WIDTH+2) entries holding {frame_error, parity_error, rx_data}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH. count is a separate registered counter.
- push = rx_valid. pop = rd_ready & rd_valid.
- push accepted: when !full, or when full and pop occurs in the same cycle.
  - Writes mem[wr_ptr] and increments wr_ptr.
- pop: increments rd_ptr. A pop while empty is ignored, and no pointer moves.
- count update: +1 on accepted push without pop, −1 on pop without push, unchanged when both or neither occur.
- Dropped push (full and no pop): the entry is discarded and fifo_overrun is set. Existing contents are unchanged.
- Priority order for fifo_overrun: reset > set by a drop > clear_overrun. If a drop and clear_overrun occur in the same cycle, the flag remains 1.
- flush has priority over push and pop in the same cycle.
  - Sets wr_ptr = rd_ptr = 0 and count = 0.
  - Does not affect fifo_overrun.
- rd_data, rd_parity_err and rd_frame_err are driven combinationally from mem[rd_ptr]. They are defined only while rd_valid = 1.
- Storage is not reset. Only the pointers, count and flags are reset.

## Timing
- Reset values: rd_valid 0, empty 1, full 0, almost_full 0, count 0, fifo_overrun 0. rd_* data outputs are don't-care.
- Write-to-read latency: a push accepted at edge N into an empty FIFO gives rd_valid = 1 and valid rd_data after edge N. The entry is visible in cycle N+1.
- Pop handshake: the entry is consumed at the edge where rd_valid & rd_ready = 1. The next head entry appears in the following cycle with no bubble.
- Sustained throughput: one push and one pop per cycle.
- empty, full, almost_full and rd_valid are derived from the registered count. All of them update one cycle after the causing edge.
- fifo_overrun goes high in the cycle after the dropping edge.
- Simultaneous push and pop when empty: the pop is ignored and the push is accepted, giving count = 1.
- Reset asserted mid-operation: pointers, count and flags clear immediately, asynchronously. Outputs follow the reset values while reset is held.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on three consecutive cycles, then pop three times.
  - Required: rd_data reads 0x41, 0x42, 0x43 in order; count goes 0→1→2→3→2→1→0; empty returns to 1.
- Push 16 entries 0x00..0x0F (DEPTH 16).
  - Required: full = 1 and count = 16; almost_full rises when count reaches 12.
  - A 17th push of 0xFF sets fifo_overrun = 1. The head stays 0x00, and draining all 16 returns 0x00..0x0F.
- While full, issue push 0xAA together with a pop in the same cycle.
  - Required: 0xAA is accepted, count stays 16, fifo_overrun stays 0, and after draining the last entry read is 0xAA.
- Push 0x55 with parity_error = 1, then 0x66 with frame_error = 1.
  - Required: the first pop shows rd_parity_err = 1 and rd_frame_err = 0; the second shows rd_parity_err = 0 and rd_frame_err = 1.
- With 5 entries stored, assert flush together with push 0x77 and rd_ready.
  - Required: the next cycle shows count = 0, empty = 1 and rd_valid = 0; 0x77 is not stored.
- Assert clear_overrun in the same cycle as a dropped write.
  - Required: fifo_overrun remains 1. A later clear_overrun with no drop gives 0.
- Assert reset asynchronously mid-burst.
  - Required: count = 0 and empty = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Write and read handshake bundle between the UART receiver, the receive FIFO and the host.
// The FIFO takes the slave modport; the receiver/host side takes the master modport.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  parity_error;
  logic                  frame_error;
  logic                  flush;
  logic                  clear_overrun;
  logic                  rd_ready;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_parity_err;
  logic                  rd_frame_err;
  logic                  rd_valid;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  fifo_overrun;

  modport master (
    output rx_data, rx_valid, parity_error, frame_error, flush, clear_overrun, rd_ready,
    input  rd_data, rd_parity_err, rd_frame_err, rd_valid, count, empty, full,
           almost_full, fifo_overrun
  );

  modport slave (
    input  rx_data, rx_valid, parity_error, frame_error, flush, clear_overrun, rd_ready,
    output rd_data, rd_parity_err, rd_frame_err, rd_valid, count, empty, full,
           almost_full, fifo_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO buffering received UART characters with their parity/frame status.
// Tracks fill level with a registered counter and flags dropped writes in a sticky overrun bit.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overrun_q;

  logic          is_empty;
  logic          is_full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] head;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = bus.rd_ready & ~is_empty;
  assign push_ok  = bus.rx_valid & (~is_full | pop);
  // A flush supersedes the write, so it is neither stored nor counted as a drop.
  assign drop     = bus.rx_valid & is_full & ~pop & ~bus.flush;

  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush) begin
      mem[wr_ptr] <= {bus.frame_error, bus.parity_error, bus.rx_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A drop in the same cycle as clear_overrun wins, so the flag is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.clear_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign head              = mem[rd_ptr];
  assign bus.rd_data       = head[DATA_WIDTH-1:0];
  assign bus.rd_parity_err = head[DATA_WIDTH];
  assign bus.rd_frame_err  = head[DATA_WIDTH+1];
  assign bus.rd_valid      = ~is_empty;
  assign bus.count         = count_q;
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.almost_full   = (count_q >= CW'(AF_LEVEL));
  assign bus.fifo_overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: queue of {frame_error, parity_error, data}, plus the sticky overrun bit.
  logic [DW+1:0] q [$];
  logic          ov;

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic pe, input logic fe,
                       input logic rdy, input logic fl, input logic clr);
    bus.rx_valid      = v;
    bus.rx_data       = d;
    bus.parity_error  = pe;
    bus.frame_error   = fe;
    bus.rd_ready      = rdy;
    bus.flush         = fl;
    bus.clear_overrun = clr;
  endtask

  task automatic tick();
    logic was_full;
    logic do_pop;
    logic drop;
    logic [DW+1:0] entry;
    was_full = (q.size() == DEPTH);
    do_pop   = bus.rd_ready && (q.size() > 0);
    drop     = 1'b0;
    entry    = {bus.frame_error, bus.parity_error, bus.rx_data};
    if (bus.flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (bus.rx_valid) begin
        if (!was_full || do_pop) q.push_back(entry);
        else drop = 1'b1;
      end
    end
    if (drop) ov = 1'b1;
    else if (bus.clear_overrun) ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (bus.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", bus.empty); end
    if (bus.full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", bus.full); end
    if (bus.almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_af: got %b want 0", bus.almost_full); end
    if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
    if (bus.fifo_overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b want 0", bus.fifo_overrun); end
    reset = 1'b0;
    q.delete();
    ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] chars [3];
    chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      drive(1, chars[i], 0, 0, 0, 0, 0);
      tick();
      total++;
      if (bus.count !== 5'(i + 1)) begin bad++; $display("[TB] FAIL basic_fill_count: got %0d want %0d", bus.count, i + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== chars[i]) begin
        bad++; $display("[TB] FAIL basic_rd_data: got %h (valid %b) want %h", bus.rd_data, bus.rd_valid, chars[i]);
      end
      drive(0, '0, 0, 0, 1, 0, 0);
      tick();
      total++;
      if (bus.count !== 5'(2 - i)) begin bad++; $display("[TB] FAIL basic_drain_count: got %0d want %0d", bus.count, 2 - i); end
    end
    drive(0, '0, 0, 0, 0, 0, 0);
    total++;
    if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL basic_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'(i), 0, 0, 0, 0, 0);
      tick();
      total += 2;
      if (bus.count !== 5'(i + 1)) begin bad++; $display("[TB] FAIL fill_count: got %0d want %0d", bus.count, i + 1); end
      if (bus.almost_full !== (i + 1 >= AF)) begin bad++; $display("[TB] FAIL fill_af: got %b at count %0d", bus.almost_full, i + 1); end
    end
    total++;
    if (bus.full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b want 1", bus.full); end
    drive(1, 8'hFF, 0, 0, 0, 0, 0);
    tick();
    total += 3;
    if (bus.fifo_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overflow_flag: got %b want 1", bus.fifo_overrun); end
    if (bus.count !== 5'd16) begin bad++; $display("[TB] FAIL overflow_count: got %0d want 16", bus.count); end
    if (bus.rd_data !== 8'h00) begin bad++; $display("[TB] FAIL overflow_head: got %h want 00", bus.rd_data); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.rd_data !== 8'(i)) begin bad++; $display("[TB] FAIL overflow_drain: got %h want %h", bus.rd_data, 8'(i)); end
      drive(0, '0, 0, 0, 1, 0, 0);
      tick();
    end
    total++;
    if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL overflow_empty: got %b want 1", bus.empty); end
    drive(0, '0, 0, 0, 0, 0, 1);
    tick();
    total++;
    if (bus.fifo_overrun !== 1'b0) begin bad++; $display("[TB] FAIL overflow_clear: got %b want 0", bus.fifo_overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [DW+1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'($urandom), 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 8'hAA, 0, 0, 1, 0, 0);
    tick();
    total += 2;
    if (bus.count !== 5'd16) begin bad++; $display("[TB] FAIL fullpp_count: got %0d want 16", bus.count); end
    if (bus.fifo_overrun !== 1'b0) begin bad++; $display("[TB] FAIL fullpp_overrun: got %b want 0", bus.fifo_overrun); end
    exp = '0;
    while (q.size() > 0) begin
      exp = q[0];
      total++;
      if (bus.rd_data !== exp[DW-1:0]) begin bad++; $display("[TB] FAIL fullpp_drain: got %h want %h", bus.rd_data, exp[DW-1:0]); end
      drive(0, '0, 0, 0, 1, 0, 0);
      tick();
    end
    total++;
    if (exp[DW-1:0] !== 8'hAA) begin bad++; $display("[TB] FAIL fullpp_last: got %h want aa", exp[DW-1:0]); end
  endtask

  task automatic test_error_bits();
    drive(1, 8'h55, 1, 0, 0, 0, 0);
    tick();
    drive(1, 8'h66, 0, 1, 0, 0, 0);
    tick();
    total += 3;
    if (bus.rd_data !== 8'h55) begin bad++; $display("[TB] FAIL err_data0: got %h want 55", bus.rd_data); end
    if (bus.rd_parity_err !== 1'b1) begin bad++; $display("[TB] FAIL err_parity0: got %b want 1", bus.rd_parity_err); end
    if (bus.rd_frame_err !== 1'b0) begin bad++; $display("[TB] FAIL err_frame0: got %b want 0", bus.rd_frame_err); end
    drive(0, '0, 0, 0, 1, 0, 0);
    tick();
    total += 3;
    if (bus.rd_data !== 8'h66) begin bad++; $display("[TB] FAIL err_data1: got %h want 66", bus.rd_data); end
    if (bus.rd_parity_err !== 1'b0) begin bad++; $display("[TB] FAIL err_parity1: got %b want 0", bus.rd_parity_err); end
    if (bus.rd_frame_err !== 1'b1) begin bad++; $display("[TB] FAIL err_frame1: got %b want 1", bus.rd_frame_err); end
    drive(0, '0, 0, 0, 1, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), 0, 0, 0, 0, 0);
      tick();
    end
    total++;
    if (bus.count !== 5'd5) begin bad++; $display("[TB] FAIL flush_pre_count: got %0d want 5", bus.count); end
    drive(1, 8'h77, 0, 0, 1, 1, 0);
    tick();
    total += 3;
    if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL flush_count: got %0d want 0", bus.count); end
    if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty: got %b want 1", bus.empty); end
    if (bus.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_rd_valid: got %b want 0", bus.rd_valid); end
    drive(0, '0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL flush_no_store: got %0d want 0", bus.count); end
  endtask

  task automatic test_clear_overrun();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'($urandom), 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 8'hEE, 0, 0, 0, 0, 1);
    tick();
    total++;
    if (bus.fifo_overrun !== 1'b1) begin bad++; $display("[TB] FAIL clr_with_drop: got %b want 1", bus.fifo_overrun); end
    drive(0, '0, 0, 0, 0, 0, 1);
    tick();
    total++;
    if (bus.fifo_overrun !== 1'b0) begin bad++; $display("[TB] FAIL clr_alone: got %b want 0", bus.fifo_overrun); end
    drive(0, '0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_random();
    logic [DW+1:0] exp;
    int rdy_pct;
    for (int n = 0; n < 600; n++) begin
      rdy_pct = ((n / 100) % 2 == 0) ? 25 : 75;
      total += 6;
      if (bus.count !== 5'(q.size())) begin bad++; $display("[TB] FAIL rand_count: got %0d want %0d", bus.count, q.size()); end
      if (bus.empty !== (q.size() == 0)) begin bad++; $display("[TB] FAIL rand_empty: got %b size %0d", bus.empty, q.size()); end
      if (bus.rd_valid !== (q.size() != 0)) begin bad++; $display("[TB] FAIL rand_rd_valid: got %b size %0d", bus.rd_valid, q.size()); end
      if (bus.full !== (q.size() == DEPTH)) begin bad++; $display("[TB] FAIL rand_full: got %b size %0d", bus.full, q.size()); end
      if (bus.almost_full !== (q.size() >= AF)) begin bad++; $display("[TB] FAIL rand_af: got %b size %0d", bus.almost_full, q.size()); end
      if (bus.fifo_overrun !== ov) begin bad++; $display("[TB] FAIL rand_overrun: got %b want %b", bus.fifo_overrun, ov); end
      if (q.size() > 0) begin
        exp = q[0];
        total++;
        if ({bus.rd_frame_err, bus.rd_parity_err, bus.rd_data} !== exp) begin
          bad++; $display("[TB] FAIL rand_head: got %h want %h", {bus.rd_frame_err, bus.rd_parity_err, bus.rd_data}, exp);
        end
      end
      drive(logic'($urandom_range(99) < 55), 8'($urandom), logic'($urandom_range(7) == 0),
            logic'($urandom_range(7) == 0), logic'($urandom_range(99) < rdy_pct),
            logic'($urandom_range(63) == 0), logic'($urandom_range(15) == 0));
      tick();
    end
    drive(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'($urandom), 0, 0, 0, 0, 0);
      tick();
    end
    total++;
    if (bus.fifo_overrun !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre_overrun: got %b want 1", bus.fifo_overrun); end
    #1;
    reset = 1'b1;
    #1;
    total += 4;
    if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL areset_count: got %0d want 0", bus.count); end
    if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL areset_empty: got %b want 1", bus.empty); end
    if (bus.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_rd_valid: got %b want 0", bus.rd_valid); end
    if (bus.fifo_overrun !== 1'b0) begin bad++; $display("[TB] FAIL areset_overrun: got %b want 0", bus.fifo_overrun); end
    @(posedge clk);
    #1;
    total++;
    if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL areset_held_count: got %0d want 0", bus.count); end
    reset = 1'b0;
    q.delete();
    ov = 1'b0;
    drive(1, 8'h3C, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin
      bad++; $display("[TB] FAIL areset_recover: got %h (valid %b) want 3c", bus.rd_data, bus.rd_valid);
    end
    drive(0, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ov = 1'b0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_error_bits();
    test_flush();
    test_clear_overrun();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
